// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the CPU-to-memory bridge: FSM state encoding and the
// RISC-V exception cause codes it reports, plus small helpers that pick a
// cause from the access direction.
// -----------------------------------------------------------------------------
package cpu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [31:0] CAUSE_LOAD_MISALIGNED  = 32'd4;
  localparam logic [31:0] CAUSE_LOAD_ACCESS      = 32'd5;
  localparam logic [31:0] CAUSE_STORE_MISALIGNED = 32'd6;
  localparam logic [31:0] CAUSE_STORE_ACCESS     = 32'd7;

  function automatic logic [31:0] misaligned_cause(input logic we);
    return we ? CAUSE_STORE_MISALIGNED : CAUSE_LOAD_MISALIGNED;
  endfunction

  function automatic logic [31:0] access_fault_cause(input logic we);
    return we ? CAUSE_STORE_ACCESS : CAUSE_LOAD_ACCESS;
  endfunction

endpackage

// File: rtl/cpu_mem_bridge.sv
// -----------------------------------------------------------------------------
// cpu_mem_bridge
// Turns a single-word core access into one valid/ready beat on a memory bus
// and reports completion (with RISC-V fault cause) back to the core.
//
// Handshake: bus_valid is raised in BUSY and the request fields (bus_we,
// bus_addr, bus_wdata) are held constant until a cycle where bus_valid and
// bus_ready are both high; that cycle is the beat, and bus_rdata/bus_err are
// only looked at then. The core side has no back-pressure: cpu_req is only
// sampled in IDLE, and cpu_done pulses for exactly one cycle in RESP.
//
// Ports:
//   clk, reset          clock, asynchronous active-low reset
//   cpu_req/we/addr/wdata  core request (sampled in IDLE)
//   cpu_rdata           last successful load data (held)
//   cpu_done            one-cycle completion pulse
//   cpu_fault/cpu_cause fault flag and cause, valid with cpu_done
//   cpu_busy            bridge not in IDLE
//   bus_valid/we/addr/wdata  memory request, word-aligned address
//   bus_ready/rdata/err memory response, valid with bus_ready
//
// Configuration macro CPU_MEM_BRIDGE_TIMEOUT_EN: when defined, a BUSY state
// that sees TIMEOUT_CYCLES cycles without bus_ready gives up with an access
// fault; otherwise BUSY waits forever.
// -----------------------------------------------------------------------------
module cpu_mem_bridge
  import cpu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_done,
  output logic        cpu_fault,
  output logic [31:0] cpu_cause,
  output logic        cpu_busy,
  output logic        bus_valid,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_ready,
  input  logic [31:0] bus_rdata,
  input  logic        bus_err
);

  state_t      r_state;
  state_t      w_next;
  logic        r_we;
  logic [29:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic [31:0] r_cause;
  logic        r_fault;

  logic w_accept;
  logic w_aligned;
  logic w_hs;
  logic w_timeout;

  assign w_accept  = (r_state == ST_IDLE) & cpu_req;
  assign w_aligned = (cpu_addr[1:0] == 2'b00);
  assign w_hs      = (r_state == ST_BUSY) & bus_ready;

`ifdef CPU_MEM_BRIDGE_TIMEOUT_EN
  logic [CNT_W-1:0] r_cnt;

  // Counts consecutive non-ready BUSY cycles; cleared whenever BUSY is left.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if ((r_state == ST_BUSY) && !bus_ready) begin
      r_cnt <= r_cnt + 1'b1;
    end else begin
      r_cnt <= '0;
    end
  end

  // Terminal wait cycle; a handshake in this same cycle wins.
  assign w_timeout = (r_state == ST_BUSY) & ~bus_ready &
                     (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  logic w_unused_cfg;
  assign w_unused_cfg = (TIMEOUT_CYCLES > 0) ^ (CNT_W > 0);
  assign w_timeout    = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    cpu_done  = 1'b0;
    cpu_busy  = 1'b0;
    bus_valid = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // Misaligned accesses skip the bus and report straight away.
        if (cpu_req) w_next = w_aligned ? ST_BUSY : ST_RESP;
      end
      ST_BUSY: begin
        cpu_busy  = 1'b1;
        bus_valid = 1'b1;
        if (bus_ready || w_timeout) w_next = ST_RESP;
      end
      ST_RESP: begin
        cpu_busy = 1'b1;
        cpu_done = 1'b1;
        w_next   = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_fault <= 1'b0;
      r_cause <= '0;
    end else if (w_accept) begin
      r_we    <= cpu_we;
      r_addr  <= cpu_addr[31:2];
      r_wdata <= cpu_wdata;
      r_fault <= ~w_aligned;
      r_cause <= w_aligned ? 32'd0 : misaligned_cause(cpu_we);
    end else if (w_hs) begin
      if (bus_err) begin
        r_fault <= 1'b1;
        r_cause <= access_fault_cause(r_we);
      end else if (!r_we) begin
        r_rdata <= bus_rdata;
      end
    end else if (w_timeout) begin
      r_fault <= 1'b1;
      r_cause <= access_fault_cause(r_we);
    end
  end

  assign cpu_rdata = r_rdata;
  assign cpu_fault = cpu_done & r_fault;
  assign cpu_cause = cpu_fault ? r_cause : 32'd0;
  // Request fields read as zero outside BUSY so nothing leaks onto the bus.
  assign bus_we    = bus_valid & r_we;
  assign bus_addr  = bus_valid ? {r_addr, 2'b00} : 32'd0;
  assign bus_wdata = bus_valid ? r_wdata : 32'd0;

endmodule

// File: doc/cpu_mem_bridge.md
CPU_MEM_BRIDGE -- requirements
Module: cpu_mem_bridge

Interface
REQ-001 Parameters SHALL be: TIMEOUT_CYCLES, 16, bus cycles waited for bus_ready before fault; CNT_W, 8, timeout counter width.
REQ-002 One clock; reset is asynchronous and active-low.
REQ-003 Ports SHALL be, in order:
  clk  in  1  rising-edge clock;
  reset  in  1  async active-low reset;
  cpu_req  in  1  access request from the core, sampled in IDLE only;
  cpu_we  in  1  1=store, 0=load;
  cpu_addr  in  32  byte address;
  cpu_wdata  in  32  store data;
  cpu_rdata  out  32  load data;
  cpu_done  out  1  one-cycle completion pulse;
  cpu_fault  out  1  qualifies cpu_done, access failed;
  cpu_cause  out  32  RISC-V exception code, valid with cpu_fault;
  cpu_busy  out  1  bridge not in IDLE;
  bus_valid  out  1  request valid to memory;
  bus_we  out  1  write strobe;
  bus_addr  out  32  word-aligned address;
  bus_wdata  out  32  write data;
  bus_ready  in  1  memory accepts/completes beat;
  bus_rdata  in  32  read data, valid with bus_ready;
  bus_err  in  1  slave error, valid with bus_ready.

Function
REQ-004 FSM SHALL have states IDLE, BUSY, RESP; state encoding from the shared package.
REQ-005 IDLE & cpu_req: latch cpu_we/addr/wdata; if addr[1:0]==0 go BUSY, else go RESP with fault, no bus activity.
REQ-006 Misaligned cause SHALL be 32'd4 (load) or 32'd6 (store).
REQ-007 BUSY: bus_valid=1; bus_we/addr/wdata SHALL be driven from latched values and held stable until handshake.
REQ-008 Handshake = bus_valid & bus_ready in same cycle; on handshake go RESP; load captures bus_rdata into cpu_rdata.
REQ-009 bus_err at handshake SHALL give fault, cause 32'd5 (load) or 32'd7 (store); cpu_rdata unchanged.
REQ-010 RESP: cpu_done=1 exactly one cycle, cpu_fault/cpu_cause valid that cycle; next state IDLE.
REQ-011 Latency: req accepted edge N, bus_valid from N+1; ready at N+1 gives cpu_done at N+2; each wait cycle adds one.
REQ-012 cpu_rdata SHALL hold its value until the next successful load; cpu_cause SHALL read 0 except with cpu_fault.
REQ-013 cpu_req outside IDLE SHALL be ignored; cpu_busy=1 in BUSY and RESP.
REQ-014 Stores SHALL never modify cpu_rdata.

Reset
REQ-015 reset low SHALL immediately force IDLE, clear counter, drive every output to 0 (cpu_rdata 32'h0), including mid-transaction with bus_valid dropping asynchronously.
REQ-016 First request accepted on first rising edge after reset deasserts.

Configuration
REQ-017 Macro CPU_MEM_BRIDGE_TIMEOUT_EN defined: counter increments each BUSY cycle without handshake; at TIMEOUT_CYCLES non-ready cycles drop bus_valid, go RESP with access-fault cause (5/7); handshake in the terminal cycle takes priority.
REQ-018 Macro undefined: no counter, BUSY waits indefinitely; CNT_W unused.

Structure
REQ-019 Shared package cpu_pkg SHALL hold FSM state typedef and cause constants (4,5,6,7).
REQ-020 Single flat module; no sub-module required.

Verification
REQ-021 Load 0x100, bus_ready same cycle as bus_valid, bus_rdata 0xDEADBEEF -> cpu_done at N+2, cpu_rdata 0xDEADBEEF, cpu_fault 0.
REQ-022 Store 0x204 data 0x12345678, bus_ready after 3 wait cycles -> bus_* stable throughout, cpu_done at N+5, cpu_rdata unchanged.
REQ-023 Load 0x102 -> no bus_valid, cpu_done at N+1, cpu_fault 1, cpu_cause 4; store 0x103 -> cause 6.
REQ-024 Store with bus_err at handshake -> cpu_fault 1, cause 7; with macro on, load never ready -> fault cause 5 after 16 BUSY cycles.
REQ-025 reset low during BUSY -> bus_valid 0 same cycle, all outputs 0; cpu_req held during BUSY/RESP -> exactly one bus transaction.
